// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared NPU constants and BRAM reader state encoding
package npu_pkg;

    localparam int BRAM_ADDR_WIDTH = 10;
    localparam int WEIGHT_WIDTH    = 8;
    localparam int BRAM_DEPTH      = 784;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } reader_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - 2-entry valid/ready buffer; head register keeps its data after it drains
module skid_fifo2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d;
    logic             head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
    logic             pop;

    // Writer is credit-limited to the free space, so no in_ready is needed.
    always_comb begin
        head_d       = head_q;
        head_valid_d = head_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        pop          = head_valid_q && out_ready_i;
        if (!head_valid_q || pop) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                head_valid_d = 1'b1;
                skid_valid_d = in_valid_i;
                if (in_valid_i) begin
                    skid_d = in_data_i;
                end
            end else if (in_valid_i) begin
                head_d       = in_data_i;
                head_valid_d = 1'b1;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (in_valid_i) begin
            skid_d       = in_data_i;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_data_o  = head_q;
    assign out_valid_o = head_valid_q;
    assign count_o     = {1'b0, head_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - sweeps a BRAM address window and streams the words out with last/done
// BRAM_SYNC_READ_EN: registered-read BRAM, one read in flight plus a skid_fifo2 in front of o_data.
module bram_stream_reader
    import npu_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_len,
    output logic [BRAM_ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [WEIGHT_WIDTH-1:0]    i_rd_data,
    output logic [WEIGHT_WIDTH-1:0]    o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_last,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE    = 1;
    localparam logic [BRAM_ADDR_WIDTH:0]   DEPTH_LIMIT = (BRAM_ADDR_WIDTH + 1)'(BRAM_DEPTH);

    reader_state_e               state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0]  base_q, base_d, len_q, len_d, idx_q, idx_d;
    logic [BRAM_ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic                        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [BRAM_ADDR_WIDTH:0]    end_addr;
    logic                        issue, is_last_req, beat_accept;

`ifdef BRAM_SYNC_READ_EN
    logic                        inflight_q, inflight_d, inflight_last_q, inflight_last_d;
    logic [1:0]                  fifo_count, occupancy;
    logic [WEIGHT_WIDTH:0]       fifo_data;
    logic                        fifo_valid;

    skid_fifo2 #(.WIDTH(WEIGHT_WIDTH + 1)) u_skid (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .in_data_i   ({inflight_last_q, i_rd_data}),
        .in_valid_i  (inflight_q),
        .out_data_o  (fifo_data),
        .out_valid_o (fifo_valid),
        .out_ready_i (i_ready),
        .count_o     (fifo_count)
    );

    assign {o_last, o_data} = fifo_data;
    assign o_valid          = fifo_valid;
    // Credit counts the slot freed by this cycle's pop so steady state stays at 1 beat/cycle.
    assign occupancy        = {1'b0, inflight_q} + fifo_count - {1'b0, beat_accept};
`else
    logic [WEIGHT_WIDTH-1:0]     data_q, data_d;
    logic                        valid_q, valid_d, last_q, last_d;

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;
`endif

    assign end_addr    = {1'b0, i_base_addr} + {1'b0, i_len};
    assign is_last_req = (idx_q == len_q - ADDR_ONE);
    assign beat_accept = o_valid && i_ready;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        issue     = 1'b0;
`ifdef BRAM_SYNC_READ_EN
        inflight_d      = 1'b0;
        inflight_last_d = inflight_last_q;
`else
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_len == '0) begin
                        done_d = 1'b1;
                    end else if (end_addr > DEPTH_LIMIT) begin
                        err_d = 1'b1;
                    end else begin
                        base_d    = i_base_addr;
                        len_d     = i_len;
                        idx_d     = '0;
                        rd_addr_d = i_base_addr;
                        busy_d    = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
`ifdef BRAM_SYNC_READ_EN
                issue = (occupancy < 2'd2) && (idx_q < len_q);
`else
                issue = (!valid_q || i_ready) && (idx_q < len_q);
`endif
                if (issue) begin
                    idx_d = idx_q + ADDR_ONE;
`ifdef BRAM_SYNC_READ_EN
                    inflight_d      = 1'b1;
                    inflight_last_d = is_last_req;
`else
                    data_d  = i_rd_data;
                    valid_d = 1'b1;
                    last_d  = is_last_req;
`endif
                    // Address stays on the final word so it never leaves the valid BRAM range.
                    if (is_last_req) begin
                        state_d = FLUSH;
                    end else begin
                        rd_addr_d = base_q + idx_q + ADDR_ONE;
                    end
                end
`ifndef BRAM_SYNC_READ_EN
                else if (beat_accept) begin
                    valid_d = 1'b0;
                end
`endif
            end
            FLUSH: begin
                if (beat_accept && o_last) begin
`ifndef BRAM_SYNC_READ_EN
                    valid_d = 1'b0;
`endif
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef BRAM_SYNC_READ_EN
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
`else
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef BRAM_SYNC_READ_EN
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
`else
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
`endif
        end
    end

    assign o_rd_addr = rd_addr_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;

endmodule
